// File: rtl/sweep_pkg.sv
// sweep_pkg: shared sweep constants, expected-pattern function and decoder FSM states
package sweep_pkg;
  localparam int SWEEP_PERIOD = 18;
  localparam int SWEEP_DWELL = 5;
  localparam int SWEEP_W = 8;
  localparam int PHASE_W = 5;
  localparam int FALL_START = SWEEP_DWELL + SWEEP_W - 2;
  typedef enum logic [1:0] {HUNT, SEEK, CHECK, LOCKED} sweep_state_e;
  function automatic logic [SWEEP_W-1:0] sweep_expected(input logic [PHASE_W-1:0] p);
    return (p < PHASE_W'(SWEEP_DWELL - 1) || p == PHASE_W'(SWEEP_PERIOD - 1)) ? SWEEP_W'(1) :
           (p < PHASE_W'(FALL_START)) ? SWEEP_W'(1) << (p - PHASE_W'(SWEEP_DWELL - 2)) :
           SWEEP_W'(1) << (PHASE_W'(SWEEP_PERIOD - 1) - p);
  endfunction
endpackage

// File: rtl/onehot_enc8.sv
// onehot_enc8: flags an exactly-one-hot byte and encodes the index of its set bit
module onehot_enc8 (
  input  logic [7:0] data_i,
  output logic       is_onehot_o,
  output logic [2:0] index_o
);
  assign is_onehot_o = (data_i != 8'd0) && ((data_i & (data_i - 8'd1)) == 8'd0);
  // priority encode; only meaningful when the input is one-hot
  always_comb begin
    index_o = 3'd0;
    for (int i = 0; i < 8; i++) if (data_i[i]) index_o = 3'(i);
  end
endmodule

// File: rtl/shift_pattern_decoder.sv
// shift_pattern_decoder: locks onto the bouncing one-hot sweep and reports phase, position, direction and errors
module shift_pattern_decoder
  import sweep_pkg::*;
#(
  parameter int LOCK_CYCLES = 18,
  parameter int MISS_LIMIT = 3,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [SWEEP_W-1:0] count_in,
  output logic               locked,
  output logic [PHASE_W-1:0] phase,
  output logic [2:0]         position,
  output logic               dir,
  output logic               period_done,
  output logic               onehot_err,
  output logic               seq_err,
  output logic [ERR_W-1:0]   err_count
);
  localparam int MW = $clog2(LOCK_CYCLES + 1);
  localparam int NW = $clog2(MISS_LIMIT + 1);
  sweep_state_e state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_nx;
  logic [2:0] pos_q, pos_d, idx;
  logic [MW-1:0] match_q, match_d;
  logic [NW-1:0] miss_q, miss_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic pd_q, pd_d, oh_q, oh_d, seq_q, seq_d, is_onehot, hit;
  onehot_enc8 u_enc (.data_i(count_in), .is_onehot_o(is_onehot), .index_o(idx));
  assign phase_nx = (phase_q == PHASE_W'(SWEEP_PERIOD - 1)) ? '0 : phase_q + PHASE_W'(1);
  assign hit = count_in == sweep_expected(phase_nx);
  assign locked = state_q == LOCKED;
  assign dir = locked && phase_q >= PHASE_W'(FALL_START);
  assign phase = phase_q;
  assign position = pos_q;
  assign period_done = pd_q;
  assign onehot_err = oh_q;
  assign seq_err = seq_q;
  assign err_count = err_q;
  // next state: acquisition, lock tracking with flywheel phase, error accounting
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pos_d = pos_q;
    match_d = match_q;
    miss_d = miss_q;
    err_d = err_q;
    pd_d = 1'b0;
    oh_d = 1'b0;
    seq_d = 1'b0;
    if (in_valid) begin
      oh_d = !is_onehot;
      pos_d = is_onehot ? idx : pos_q;
      case (state_q)
        HUNT: state_d = (count_in == SWEEP_W'(1)) ? SEEK : HUNT;
        SEEK: begin
          state_d = (count_in == SWEEP_W'(2)) ? CHECK : (count_in == SWEEP_W'(1)) ? SEEK : HUNT;
          phase_d = (count_in == SWEEP_W'(2)) ? PHASE_W'(SWEEP_DWELL - 1) : phase_q;
          match_d = (count_in == SWEEP_W'(2)) ? MW'(1) : '0;
        end
        CHECK: begin
          state_d = !hit ? HUNT : (match_q == MW'(LOCK_CYCLES - 1)) ? LOCKED : CHECK;
          match_d = hit ? match_q + MW'(1) : '0;
          phase_d = hit ? phase_nx : phase_q;
          pd_d = hit && phase_nx == '0;
        end
        LOCKED: begin
          seq_d = !hit;
          err_d = (hit || &err_q) ? err_q : err_q + ERR_W'(1);
          miss_d = hit ? '0 : miss_q + NW'(1);
          phase_d = phase_nx;
          pd_d = phase_nx == '0;
          if (!hit && miss_q == NW'(MISS_LIMIT - 1)) begin
            state_d = HUNT;
            miss_d = '0;
            match_d = '0;
            phase_d = phase_q;
            pd_d = 1'b0;
          end
        end
      endcase
    end
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      phase_q <= '0;
      pos_q <= '0;
      match_q <= '0;
      miss_q <= '0;
      err_q <= '0;
      pd_q <= 1'b0;
      oh_q <= 1'b0;
      seq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pos_q <= pos_d;
      match_q <= match_d;
      miss_q <= miss_d;
      err_q <= err_d;
      pd_q <= pd_d;
      oh_q <= oh_d;
      seq_q <= seq_d;
    end
  end
endmodule

// File: tb/tb_shift_pattern_decoder.sv
// tb_shift_pattern_decoder: directed vectors against hand-built sweep tables
module tb_shift_pattern_decoder;
  logic clk = 1'b0;
  logic reset, in_valid;
  logic [7:0] count_in;
  logic locked, dir, period_done, onehot_err, seq_err;
  logic [4:0] phase;
  logic [2:0] position;
  logic [7:0] err_count;
  logic s_locked, s_dir, s_period_done, s_onehot_err, s_seq_err;
  logic [4:0] s_phase;
  logic [2:0] s_position;
  logic [7:0] s_err_count;
  int n_tests = 0;
  int n_fail = 0;
  int g = 0;
  logic [7:0] pat [18] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                           8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  int ppos [18] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

  shift_pattern_decoder u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .locked(locked), .phase(phase), .position(position), .dir(dir),
    .period_done(period_done), .onehot_err(onehot_err), .seq_err(seq_err), .err_count(err_count)
  );

  shift_pattern_decoder #(.MISS_LIMIT(400)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .count_in(count_in),
    .locked(s_locked), .phase(s_phase), .position(s_position), .dir(s_dir),
    .period_done(s_period_done), .onehot_err(s_onehot_err), .seq_err(s_seq_err), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input logic v, input logic [7:0] d);
    in_valid = v;
    count_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gen();
    feed(1'b1, pat[g]);
    g = (g + 1) % 18;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    count_in = 8'h00;
    #12;
    check("rst_locked", locked, 0);
    check("rst_phase", phase, 0);
    check("rst_pos", position, 0);
    check("rst_pulses", {period_done, onehot_err, seq_err, dir}, 0);
    check("rst_err", err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    g = 0;
    for (int k = 0; k < 37; k++) begin
      int p;
      p = k % 18;
      gen();
      check("acq_locked", locked, int'(k >= 21));
      check("acq_phase", phase, k < 4 ? 0 : p);
      check("acq_pos", position, ppos[p]);
      check("acq_dir", dir, int'(k >= 21 && p >= 11));
      check("acq_period_done", period_done, int'(k == 18 || k == 36));
      check("acq_errs", {onehot_err, seq_err}, 0);
    end
    check("acq_err_count", err_count, 0);
    feed(1'b1, 8'h00);
    g = 2;
    check("zero_onehot_err", onehot_err, 1);
    check("zero_seq_err", seq_err, 1);
    check("zero_err_count", err_count, 1);
    check("zero_locked", locked, 1);
    check("zero_phase", phase, 1);
    check("zero_pos_hold", position, 0);
    gen();
    check("fly_errs", {onehot_err, seq_err}, 0);
    check("fly_phase", phase, 2);
    check("fly_locked", locked, 1);
    repeat (4) gen();
    check("pre_hold_phase", phase, 6);
    check("pre_hold_pos", position, 3);
    for (int i = 0; i < 5; i++) begin
      feed(1'b0, 8'hFF);
      check("hold_phase", phase, 6);
      check("hold_pos", position, 3);
      check("hold_locked", locked, 1);
      check("hold_pulses", {period_done, onehot_err, seq_err}, 0);
    end
    gen();
    check("resume_phase", phase, 7);
    check("resume_pos", position, 4);
    check("resume_seq_err", seq_err, 0);
    repeat (5) gen();
    check("fall_phase", phase, 12);
    check("fall_dir", dir, 1);
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, 8'h80);
      check("miss_seq_err", seq_err, 1);
      check("miss_err_count", err_count, 2 + i);
      check("miss_locked", locked, int'(i < 2));
      check("miss_pos", position, 7);
    end
    check("drop_dir", dir, 0);
    feed(1'b1, 8'h80);
    check("hunt_seq_err", seq_err, 0);
    check("hunt_err_count", err_count, 4);
    check("hunt_locked", locked, 0);
    g = 0;
    for (int k = 0; k < 28; k++) begin
      gen();
      if (k == 4) check("relock_check_phase", phase, 4);
      if (k == 20) check("relock_not_yet", locked, 0);
      if (k == 21) check("relock_locked", locked, 1);
      if (k == 21) check("relock_phase", phase, 3);
    end
    check("pre_reset_phase", phase, 9);
    check("pre_reset_err", err_count, 4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_phase", phase, 0);
    check("arst_pos", position, 0);
    check("arst_pulses", {period_done, onehot_err, seq_err, dir}, 0);
    check("arst_err", err_count, 0);
    check("arst_sat_err", s_err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    g = 0;
    repeat (22) gen();
    check("sat_main_locked", locked, 1);
    check("sat_dut_locked", s_locked, 1);
    check("sat_phase", s_phase, 3);
    for (int i = 0; i < 300; i++) begin
      feed(1'b1, 8'h00);
      if (i == 253) check("sat_254", s_err_count, 254);
      if (i == 254) check("sat_255", s_err_count, 255);
    end
    check("sat_final", s_err_count, 255);
    check("sat_still_locked", s_locked, 1);
    check("sat_seq_err", s_seq_err, 1);
    check("main_err_after_drop", err_count, 3);
    check("main_unlocked", locked, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
